// File: rtl/ex_muldiv_sequencer_if.sv
// Request/result bundle between the EX-stage pipeline and the iterative multiply/divide unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface ex_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MthiWrite;
    logic             MtloWrite;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, MthiWrite, MtloWrite, WriteData,
        input  Busy, Done, DivZero, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, MthiWrite, MtloWrite, WriteData,
        output Busy, Done, DivZero, HI, LO
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and performs one shift-add or restoring-divide step per clock.
// Signed operations run on magnitudes; the signs are applied in a single fix-up cycle.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    ex_muldiv_sequencer_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [1:0]         op_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               div_zero_reg;

    logic               accept;
    logic               signed_in;
    logic               div_zero_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        accept      = bus.Start && ((state_reg == IDLE) || (state_reg == DONE));
        signed_in   = ~bus.Op[0];
        div_zero_in = bus.Op[1] && (bus.B == '0);
        abs_a       = (signed_in && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        abs_b       = (signed_in && bus.B[WIDTH-1]) ? -bus.B : bus.B;

        // Multiply: acc holds {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, operand_reg};
        mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                              : {1'b0, acc_reg[2*WIDTH-1:1]};

        // Divide: acc holds {remainder, dividend bits becoming quotient bits}.
        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand_reg};
        rem_ge    = (rem_shift >= {1'b0, operand_reg});
        div_next  = rem_ge ? {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                           : {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

        prod_fix = (op_reg == 2'b00 && (sign_a_reg ^ sign_b_reg)) ? -acc_reg : acc_reg;
        quot_fix = (op_reg == 2'b10 && (sign_a_reg ^ sign_b_reg)) ? -acc_reg[WIDTH-1:0]
                                                                  : acc_reg[WIDTH-1:0];
        rem_fix  = (op_reg == 2'b10 && sign_a_reg) ? -acc_reg[2*WIDTH-1:WIDTH]
                                                   : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            op_reg       <= 2'b00;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            operand_reg  <= '0;
            acc_reg      <= '0;
            count_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    acc_reg   <= op_reg[1] ? div_next : mul_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1))
                        state_reg <= FIX;
                end
                FIX: begin
                    if (op_reg[1]) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                    state_reg <= DONE;
                end
                default: begin
                    // IDLE and DONE behave identically so DONE can accept back-to-back work.
                    div_zero_reg <= 1'b0;
                    state_reg    <= IDLE;
                    if (bus.MthiWrite)
                        hi_reg <= bus.WriteData;
                    if (bus.MtloWrite)
                        lo_reg <= bus.WriteData;
                    if (accept) begin
                        op_reg      <= bus.Op;
                        sign_a_reg  <= signed_in & bus.A[WIDTH-1];
                        sign_b_reg  <= signed_in & bus.B[WIDTH-1];
                        count_reg   <= '0;
                        operand_reg <= bus.Op[1] ? abs_b : abs_a;
                        acc_reg     <= bus.Op[1] ? {{WIDTH{1'b0}}, abs_a}
                                                 : {{WIDTH{1'b0}}, abs_b};
                        if (div_zero_in) begin
                            hi_reg       <= bus.A;
                            lo_reg       <= '1;
                            div_zero_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Busy    = (state_reg == RUN) || (state_reg == FIX);
    assign bus.Done    = (state_reg == DONE);
    assign bus.DivZero = div_zero_reg;
    assign bus.HI      = hi_reg;
    assign bus.LO      = lo_reg;
endmodule
